// File: rtl/weight_bit_serializer_pkg.sv
// Shared widths, frame constants and state encoding for the bit-serial weight link.
package weight_bit_serializer_pkg;

  localparam int unsigned WEIGHT_W       = 16;
  localparam int unsigned MAG_W          = 15;
  localparam int unsigned BITS_PER_FRAME = 16;
  localparam int unsigned CNT_W          = 4;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BITS_PER_FRAME - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  // Magnitude goes out MSB first (bit 14 at position 0); position 15 carries the sign.
  function automatic logic sel_bit(input logic [WEIGHT_W-1:0] w,
                                   input logic [CNT_W-1:0]    pos);
    logic [CNT_W-1:0] idx;
    idx = (pos == LAST_BIT) ? LAST_BIT : (CNT_W'(MAG_W - 1) - pos);
    return w[idx];
  endfunction

endpackage

// File: rtl/weight_skid_reg.sv
// One-entry holding register for the next weight; w_ready is simply "holding slot empty".
module weight_skid_reg
  import weight_bit_serializer_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic                pop,
  input  logic [WEIGHT_W-1:0] w_data,
  output logic [WEIGHT_W-1:0] hreg,
  output logic                hfull,
  output logic                w_ready
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hreg  <= '0;
      hfull <= 1'b0;
    end else if (push) begin
      hreg  <= w_data;
      hfull <= 1'b1;
    end else if (pop) begin
      hfull <= 1'b0;
    end
  end

  assign w_ready = ~hfull;

endmodule

// File: rtl/weight_bit_serializer.sv
// Transmit side of the bit-serial weight link: 16-bit sign-magnitude weights in,
// registered weight_bit/enable stream out, 16 bits per frame, back-to-back capable.
module weight_bit_serializer
  import weight_bit_serializer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic                  hold,
  output logic                  weight_bit,
  output logic                  enable,
  output logic                  frame_last,
  output logic [3:0]            bit_idx,
  output logic                  busy
);

  state_t              state_q, state_d;
  logic [WEIGHT_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                weight_bit_d;
  logic                enable_d;
  logic                frame_last_d;
  logic [CNT_W-1:0]    bit_idx_d;

  logic                xfer;
  logic                to_shreg;
  logic                push;
  logic                pop;
  logic [WEIGHT_W-1:0] hreg;
  logic                hfull;

  assign xfer = w_valid & w_ready;
  assign push = xfer & ~to_shreg;

  weight_skid_reg u_skid (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .w_data  (w_data),
    .hreg    (hreg),
    .hfull   (hfull),
    .w_ready (w_ready)
  );

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    weight_bit_d = weight_bit;
    enable_d     = 1'b0;
    frame_last_d = frame_last;
    bit_idx_d    = bit_idx;
    to_shreg     = 1'b0;
    pop          = 1'b0;

    unique case (state_q)
      IDLE: begin
        weight_bit_d = 1'b0;
        frame_last_d = 1'b0;
        bit_idx_d    = '0;
        if (xfer) begin
          to_shreg = 1'b1;
          shreg_d  = w_data;
          cnt_d    = '0;
          state_d  = SHIFT;
        end
      end

      SHIFT: begin
        // While held, every serial output stays frozen except enable.
        if (!hold) begin
          weight_bit_d = sel_bit(shreg_q, cnt_q);
          enable_d     = 1'b1;
          bit_idx_d    = cnt_q;
          frame_last_d = (cnt_q == LAST_BIT);
          cnt_d        = cnt_q + 1'b1;
          // Held word takes priority; when empty, a word offered on the last
          // bit bypasses the holding register so frames abut without a gap.
          if (cnt_q == LAST_BIT) begin
            cnt_d = '0;
            if (hfull) begin
              shreg_d = hreg;
              pop     = 1'b1;
            end else if (xfer) begin
              to_shreg = 1'b1;
              shreg_d  = w_data;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      cnt_q      <= '0;
      weight_bit <= 1'b0;
      enable     <= 1'b0;
      frame_last <= 1'b0;
      bit_idx    <= '0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      weight_bit <= weight_bit_d;
      enable     <= enable_d;
      frame_last <= frame_last_d;
      bit_idx    <= bit_idx_d;
    end
  end

  assign busy = (state_q == SHIFT) | hfull;

endmodule

// File: tb/tb_weight_bit_serializer.sv
// Directed self-checking bench for weight_bit_serializer.
module tb_weight_bit_serializer;

  logic        clk;
  logic        reset;
  logic [15:0] w_data;
  logic        w_valid;
  logic        w_ready;
  logic        hold;
  logic        weight_bit;
  logic        enable;
  logic        frame_last;
  logic [3:0]  bit_idx;
  logic        busy;

  int checks = 0;
  int errors = 0;

  weight_bit_serializer #(.DATA_WIDTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .w_data     (w_data),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .hold       (hold),
    .weight_bit (weight_bit),
    .enable     (enable),
    .frame_last (frame_last),
    .bit_idx    (bit_idx),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; w_data = '0; w_valid = 1'b0; hold = 1'b0;
    #13;
    checks++;
    if ({weight_bit, enable, frame_last, bit_idx, w_ready, busy} !== 9'b000_0000_10) begin
      errors++;
      $display("FAIL reset_vals: got wb=%b en=%b fl=%b idx=%0d rdy=%b busy=%b required 0 0 0 0 1 0",
               weight_bit, enable, frame_last, bit_idx, w_ready, busy);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [15:0] exp_bits;
    exp_bits = 16'b0000_1000_0000_0011;
    w_data = 16'h8401; w_valid = 1'b1;
    tick();
    w_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if ({enable, weight_bit, frame_last, bit_idx} !== {1'b1, exp_bits[15-i], (i == 15), 4'(i)}) begin
        errors++;
        $display("FAIL single_bit%0d: got en=%b wb=%b fl=%b idx=%0d required en=1 wb=%b fl=%b idx=%0d",
                 i, enable, weight_bit, frame_last, bit_idx, exp_bits[15-i], (i == 15), i);
      end
    end
    tick();
    checks++;
    if (enable !== 1'b0 || frame_last !== 1'b0) begin
      errors++;
      $display("FAIL single_after: got en=%b fl=%b required 0 0", enable, frame_last);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_bits;
    exp_bits = 32'hFFFE_0000;
    w_data = 16'h7FFF; w_valid = 1'b1;
    tick();
    w_data = 16'h0000;
    tick();
    w_valid = 1'b0;
    checks++;
    if (w_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ready_low: got %b required 0", w_ready);
    end
    for (int i = 0; i < 32; i++) begin
      if (i > 0) tick();
      checks++;
      if (enable !== 1'b1 || weight_bit !== exp_bits[31-i]) begin
        errors++;
        $display("FAIL b2b_bit%0d: got en=%b wb=%b required en=1 wb=%b", i, enable, weight_bit, exp_bits[31-i]);
      end
      if (i == 14 || i == 15) begin
        checks++;
        if (w_ready !== (i == 15)) begin
          errors++;
          $display("FAIL b2b_ready_%0d: got %b required %b", i, w_ready, (i == 15));
        end
      end
    end
    tick();
    checks++;
    if (enable !== 1'b0) begin
      errors++;
      $display("FAIL b2b_after: got en=%b required 0", enable);
    end
  endtask

  task automatic test_hold();
    logic [15:0] exp_bits;
    exp_bits = 16'b1000_0000_0000_0000;
    w_data = 16'h4000; w_valid = 1'b1;
    tick();
    w_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if ({enable, weight_bit, bit_idx} !== {1'b1, exp_bits[15-i], 4'(i)}) begin
        errors++;
        $display("FAIL hold_bit%0d: got en=%b wb=%b idx=%0d required en=1 wb=%b idx=%0d",
                 i, enable, weight_bit, bit_idx, exp_bits[15-i], i);
      end
      if (i == 5) begin
        hold = 1'b1;
        for (int h = 0; h < 3; h++) begin
          tick();
          checks++;
          if (enable !== 1'b0 || bit_idx !== 4'd5) begin
            errors++;
            $display("FAIL hold_frozen%0d: got en=%b idx=%0d required en=0 idx=5", h, enable, bit_idx);
          end
        end
        hold = 1'b0;
      end
    end
    tick();
    checks++;
    if (enable !== 1'b0) begin
      errors++;
      $display("FAIL hold_after: got en=%b required 0", enable);
    end
  endtask

  task automatic test_hold_start();
    w_data = 16'h4000; w_valid = 1'b1; hold = 1'b1;
    tick();
    w_valid = 1'b0;
    for (int h = 0; h < 2; h++) begin
      tick();
      checks++;
      if (enable !== 1'b0) begin
        errors++;
        $display("FAIL hold_start_wait%0d: got en=%b required 0", h, enable);
      end
    end
    hold = 1'b0;
    tick();
    checks++;
    if ({enable, weight_bit, bit_idx} !== {1'b1, 1'b1, 4'd0}) begin
      errors++;
      $display("FAIL hold_start_first: got en=%b wb=%b idx=%0d required en=1 wb=1 idx=0", enable, weight_bit, bit_idx);
    end
    repeat (16) tick();
  endtask

  task automatic test_hold_last();
    w_data = 16'h0001; w_valid = 1'b1;
    tick();
    w_valid = 1'b0;
    repeat (15) tick();
    hold = 1'b1; w_valid = 1'b1; w_data = 16'h7FFF;
    tick();
    w_valid = 1'b0; hold = 1'b0;
    checks++;
    if (enable !== 1'b0 || w_ready !== 1'b0) begin
      errors++;
      $display("FAIL hold_last_held: got en=%b rdy=%b required en=0 rdy=0", enable, w_ready);
    end
    tick();
    checks++;
    if ({enable, frame_last, weight_bit} !== 3'b110) begin
      errors++;
      $display("FAIL hold_last_sign: got en=%b fl=%b wb=%b required 1 1 0", enable, frame_last, weight_bit);
    end
    tick();
    checks++;
    if ({enable, weight_bit, bit_idx} !== {1'b1, 1'b1, 4'd0}) begin
      errors++;
      $display("FAIL hold_last_next: got en=%b wb=%b idx=%0d required en=1 wb=1 idx=0", enable, weight_bit, bit_idx);
    end
    repeat (16) tick();
  endtask

  task automatic test_underrun();
    logic [15:0] exp_bits;
    exp_bits = 16'b0000_0000_0000_0010;
    w_data = 16'h0001; w_valid = 1'b1;
    tick();
    w_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if (enable !== 1'b1 || weight_bit !== exp_bits[15-i]) begin
        errors++;
        $display("FAIL under_bit%0d: got en=%b wb=%b required en=1 wb=%b", i, enable, weight_bit, exp_bits[15-i]);
      end
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (enable !== 1'b0) begin
        errors++;
        $display("FAIL under_idle%0d: got en=%b required 0", k, enable);
      end
      if (k == 3) begin
        w_valid = 1'b1;
        w_data  = 16'h0001;
      end
    end
    w_valid = 1'b0;
    tick();
    checks++;
    if ({enable, bit_idx, weight_bit} !== {1'b1, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL under_restart: got en=%b idx=%0d wb=%b required en=1 idx=0 wb=0", enable, bit_idx, weight_bit);
    end
    repeat (16) tick();
  endtask

  task automatic test_reset_mid_frame();
    w_data = 16'hFFFF; w_valid = 1'b1;
    tick();
    w_data = 16'h1234;
    tick();
    w_valid = 1'b0;
    repeat (7) tick();
    checks++;
    if ({bit_idx, weight_bit, w_ready, busy} !== {4'd7, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL rst_pre: got idx=%0d wb=%b rdy=%b busy=%b required idx=7 wb=1 rdy=0 busy=1",
               bit_idx, weight_bit, w_ready, busy);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({weight_bit, enable, frame_last, bit_idx, w_ready, busy} !== 9'b000_0000_10) begin
      errors++;
      $display("FAIL rst_async: got wb=%b en=%b fl=%b idx=%0d rdy=%b busy=%b required 0 0 0 0 1 0",
               weight_bit, enable, frame_last, bit_idx, w_ready, busy);
    end
    #1 reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (enable !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rst_discard%0d: got en=%b busy=%b required 0 0", k, enable, busy);
      end
    end
    w_data = 16'h8000; w_valid = 1'b1;
    tick();
    w_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if (enable !== 1'b1 || weight_bit !== (i == 15)) begin
        errors++;
        $display("FAIL rst_negzero_bit%0d: got en=%b wb=%b required en=1 wb=%b", i, enable, weight_bit, (i == 15));
      end
    end
    tick();
  endtask

  task automatic test_loopback();
    logic [15:0] neuron;
    logic [31:0] acc;
    logic        sign;
    logic [15:0] result;
    bit          done;
    neuron = 16'h0400;
    acc = '0; sign = 1'b0; done = 1'b0;
    w_data = 16'h8800; w_valid = 1'b1;
    tick();
    w_valid = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      tick();
      if (enable) begin
        if (frame_last) begin
          sign = weight_bit ^ neuron[15];
          done = 1'b1;
        end else begin
          acc = (acc << 1) + (weight_bit ? {17'd0, neuron[14:0]} : 32'd0);
        end
      end
    end
    result = {sign, acc[24:10]};
    checks++;
    if (!done || result !== 16'h8800) begin
      errors++;
      $display("FAIL loopback: got done=%b result=%h required done=1 result=8800", done, result);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_hold();
    test_hold_start();
    test_hold_last();
    test_underrun();
    test_reset_mid_frame();
    test_loopback();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/weight_bit_serializer.md
# weight_bit_serializer

Transmit side of the bit-serial weight link. The block accepts 16-bit sign-magnitude Q5.10 weights over a valid/ready handshake and drives the `weight_bit`/`enable` pair that the bit-serial neuron multiplier consumes. Each weight is emitted as 15 magnitude bits, MSB first (bit 14 down to bit 0), followed by the sign bit (bit 15), with `enable` high for all 16 cycles. A one-entry holding register lets consecutive weights stream back-to-back with no idle cycle.

## Interface
- `DATA_WIDTH`, 16: weight width. The top bit is the sign and the rest is magnitude. Only 16 is supported.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `w_data` in 16: weight word in sign-magnitude format.
- `w_valid` in 1: `w_data` is valid.
- `w_ready` out 1: the block can accept a word. This is high whenever the holding register is empty.
- `hold` in 1: freezes the serial stream. While high, the block does not shift and drives `enable` low.
- `weight_bit` out 1: serial weight bit. Registered.
- `enable` out 1: `weight_bit` is valid this cycle. Registered.
- `frame_last` out 1: the current bit is the sign bit, i.e. the 16th bit of the frame. Registered.
- `bit_idx` out 4: position of the current bit, 0 to 15. Registered.
- `busy` out 1: a frame is in progress or a word is held.

## Operation
- Storage:
  - `shreg[15:0]`, the active word.
  - `cnt[3:0]`, the bit position.
  - `hreg[15:0]` plus `hfull`, the holding register.
- States:
  - IDLE: nothing to send.
  - SHIFT: a frame is active.
- Accept:
  - A transfer occurs when `w_valid && w_ready` at a clock edge.
  - The accepted word goes into `shreg` if the state is IDLE, or if the state is SHIFT and the current bit is the last one (`cnt==15` and `hold` low). Otherwise it goes into `hreg`.
- Bit select:
  - For `cnt` 0 to 14, `weight_bit = shreg[14-cnt]`.
  - For `cnt == 15`, `weight_bit = shreg[15]`.
- SHIFT with `hold` low: `cnt` increments and `enable` is 1.
- SHIFT with `hold` high:
  - `cnt`, `shreg` and `weight_bit` are frozen and `enable` is 0.
  - Accepting a new word into `hreg` is still allowed.
- End of frame (`cnt == 15`, not held):
  - If `hfull`: load `hreg` into `shreg`, set `cnt` to 0, clear `hfull`, and stay in SHIFT.
  - Else, if a transfer occurs this cycle: load `w_data` directly and stay in SHIFT.
  - Otherwise go to IDLE.
- Transitions: IDLE to SHIFT on a transfer.
- Data handling: no arithmetic is done on the weight. Negative zero (`0x8000`) is sent unmodified.

## Timing
- Reset values:
  - `weight_bit`, `enable` and `frame_last` are 0.
  - `bit_idx` is 0, `w_ready` is 1, `busy` is 0.
  - State is IDLE and `hfull` is 0.
- Latency:
  - A word accepted at edge N while idle produces its first bit (bit 14) with `enable=1` after edge N+1.
  - The sign bit appears 15 cycles later.
  - With no `hold`, a frame occupies exactly 16 consecutive enabled cycles.
- Back-to-back: when the next word is already held, or offered during the last bit, it starts with no gap. The stream is 32 consecutive enabled cycles for 2 words.
- Underrun: when no word is available at frame end, `enable` is 0 the next cycle. The receiver's bit counter is already back at 0, so it waits.
- `w_ready` is registered and equals `!hfull`. The block therefore never drops a word: at most one word is in `shreg` and one in `hreg`.
- A transfer in the same cycle as a `hold`-frozen last bit goes to `hreg`.
- `hold` asserted on the cycle a frame would start: `enable` stays 0 until `hold` is released, then the frame starts at bit 14.
- Reset mid-frame:
  - Every output returns to its reset value immediately, regardless of the clock.
  - Both words are discarded.
  - The receiver shares the same reset, so both ends realign at bit 0.

## Structure
- Shared package: `WEIGHT_W`=16, `MAG_W`=15, `BITS_PER_FRAME`=16, and the state enum `{IDLE, SHIFT}`.
- One sub-module, `weight_skid_reg`: the `hreg`/`hfull` holding register and its `w_ready` generation. Everything else is in the top level.

## Test plan
- Reset, then send `0x8401` once. `weight_bit` over 16 enabled cycles is 0,0,0,0,1,0,0,0,0,0,0,0,0,0,1,1. `frame_last` is high only on the 16th cycle. `enable` is 0 afterwards.
- Send `0x7FFF` and `0x0000` with `w_valid` held high. The result is 32 consecutive enabled cycles: fifteen 1s, then 0, then sixteen 0s. `w_ready` falls after the second word is held and rises again when it is loaded.
- Send `0x4000` and assert `hold` for 3 cycles at `bit_idx`=5. `enable` is low for exactly 3 cycles, `bit_idx` stays at 5, and the resumed bit sequence is identical to the unheld case.
- Underrun: send `0x0001`, then assert `w_valid` again 4 cycles after the last bit. There are exactly 4 idle cycles with `enable`=0. The second frame starts at `bit_idx`=0.
- Drop `reset` low at `bit_idx`=7 with a word held. Outputs go to reset values asynchronously and `w_ready`=1. After release, the next word `0x8000` sends fifteen 0s and then 1.
- Multiplier loopback: connect the receiver with neuron `0x0400` (1.0) and weight `0x8800` (-2.0). The receiver output is `0x8800`.
